// File: rtl/rgb2hsv_pipe.sv
// RGB565/RGB888 to HSV converter: 11-stage stallable pipeline, exact floor division.
// Optional framing checker built when RGB2HSV_PROTO_CHECK_EN is defined.
module rgb2hsv_pipe #(
    parameter bit IN_RGB888 = 1'b0,
    parameter bit H_HALF    = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] din,
    input  logic        din_vld,
    input  logic        din_sop,
    input  logic        din_eop,
    output logic        din_rdy,
    output logic [8:0]  hsv_h,
    output logic [7:0]  hsv_s,
    output logic [7:0]  hsv_v,
    output logic        dout_vld,
    output logic        dout_sop,
    output logic        dout_eop,
    input  logic        dout_rdy,
    output logic        proto_err
);
    localparam logic [1:0] REG_R = 2'd0;
    localparam logic [1:0] REG_G = 2'd1;
    localparam logic [1:0] REG_B = 2'd2;

    // One restoring step on {remainder, numerator/quotient}; the low byte ends as the quotient.
    function automatic logic [15:0] div_step(input logic [15:0] w, input logic [7:0] d);
        logic [8:0] top;
        top = w[15:7];
        if (top >= {1'b0, d}) begin
            top = top - {1'b0, d};
            return {top[7:0], w[6:0], 1'b1};
        end
        return {top[7:0], w[6:0], 1'b0};
    endfunction

    logic        stall;
    logic        adv;
    logic [11:1] vld_p, sop_p, eop_p;
    logic [7:0]  r1, g1, b1, r_x, g_x, b_x;
    logic [7:0]  mx, mn, dl, ad;
    logic [1:0]  rg;
    logic        ps;
    logic [15:0] ws [2:10];
    logic [15:0] wh [2:10];
    logic [7:0]  ds [2:9];
    logic [7:0]  dh [2:9];
    logic [7:0]  v_p [2:10];
    logic [1:0]  rg_p [2:10];
    logic        ps_p [2:10];
    logic        z_p [2:10];
    logic [8:0]  hue;
    logic [8:0]  q9;
    logic        unused_bits;

    assign stall   = dout_vld && !dout_rdy;
    assign din_rdy = !stall;
    assign adv     = !stall;
    assign dout_vld = vld_p[11];
    assign dout_sop = sop_p[11];
    assign dout_eop = eop_p[11];
    assign unused_bits = ^{ws[10][15:8], wh[10][15:8], din[23:16]};

    always_comb begin
        if (IN_RGB888) begin
            r_x = din[23:16];
            g_x = din[15:8];
            b_x = din[7:0];
        end else begin
            r_x = {din[15:11], din[15:13]};
            g_x = {din[10:5],  din[10:9]};
            b_x = {din[4:0],   din[4:2]};
        end
    end

    // Dominant channel by priority R, G, B; ps marks the "plus" direction of the hue offset.
    always_comb begin
        mx = r1;
        if (g1 > mx) mx = g1;
        if (b1 > mx) mx = b1;
        mn = r1;
        if (g1 < mn) mn = g1;
        if (b1 < mn) mn = b1;
        dl = mx - mn;
        if (r1 >= g1 && r1 >= b1) begin
            rg = REG_R;
            ps = g1 >= b1;
            ad = ps ? g1 - b1 : b1 - g1;
        end else if (g1 >= b1) begin
            rg = REG_G;
            ps = b1 >= r1;
            ad = ps ? b1 - r1 : r1 - b1;
        end else begin
            rg = REG_B;
            ps = r1 >= g1;
            ad = ps ? r1 - g1 : g1 - r1;
        end
    end

    always_comb begin
        q9 = {1'b0, wh[10][7:0]};
        case (rg_p[10])
            REG_R:   hue = ps_p[10] ? q9 : ((q9 == 9'd0) ? 9'd0 : 9'd360 - q9);
            REG_G:   hue = ps_p[10] ? 9'd120 + q9 : 9'd120 - q9;
            default: hue = ps_p[10] ? 9'd240 + q9 : 9'd240 - q9;
        endcase
        if (z_p[10]) hue = 9'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p <= '0;
            sop_p <= '0;
            eop_p <= '0;
            r1 <= '0;
            g1 <= '0;
            b1 <= '0;
            for (int k = 2; k <= 10; k++) begin
                ws[k]   <= '0;
                wh[k]   <= '0;
                v_p[k]  <= '0;
                rg_p[k] <= '0;
                ps_p[k] <= 1'b0;
                z_p[k]  <= 1'b0;
            end
            for (int k = 2; k <= 9; k++) begin
                ds[k] <= '0;
                dh[k] <= '0;
            end
            hsv_h <= '0;
            hsv_s <= '0;
            hsv_v <= '0;
        end else if (adv) begin
            vld_p <= {vld_p[10:1], din_vld};
            sop_p <= {sop_p[10:1], din_vld & din_sop};
            eop_p <= {eop_p[10:1], din_vld & din_eop};
            r1 <= r_x;
            g1 <= g_x;
            b1 <= b_x;
            ws[2]   <= {dl, 8'h00} - {8'h00, dl};
            wh[2]   <= {2'b00, ad, 6'b0} - {6'b0, ad, 2'b00};
            ds[2]   <= mx;
            dh[2]   <= dl;
            v_p[2]  <= mx;
            rg_p[2] <= rg;
            ps_p[2] <= ps;
            z_p[2]  <= (dl == 8'd0);
            for (int k = 3; k <= 10; k++) begin
                ws[k]   <= div_step(ws[k-1], ds[k-1]);
                wh[k]   <= div_step(wh[k-1], dh[k-1]);
                v_p[k]  <= v_p[k-1];
                rg_p[k] <= rg_p[k-1];
                ps_p[k] <= ps_p[k-1];
                z_p[k]  <= z_p[k-1];
            end
            for (int k = 3; k <= 9; k++) begin
                ds[k] <= ds[k-1];
                dh[k] <= dh[k-1];
            end
            hsv_h <= H_HALF ? {1'b0, hue[8:1]} : hue;
            hsv_s <= z_p[10] ? 8'd0 : ws[10][7:0];
            hsv_v <= v_p[10];
        end
    end

`ifdef RGB2HSV_PROTO_CHECK_EN
    logic in_frame;
    logic acc;
    assign acc = din_vld && din_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_frame  <= 1'b0;
            proto_err <= 1'b0;
        end else if (acc) begin
            if ((din_sop && in_frame) || (!din_sop && !in_frame)) proto_err <= 1'b1;
            if (din_eop)      in_frame <= 1'b0;
            else if (din_sop) in_frame <= 1'b1;
        end
    end
`else
    assign proto_err = 1'b0;
`endif

endmodule
